uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmitter; the transmit-side counterpart of the RX deserializer path. Accepts a parallel word with a one-cycle valid strobe and emits one serial frame, LSB first: start bit (0), DATA_WIDTH data bits, optional parity bit, stop bit (1).
- Clocked at the bit rate (one bit per CLK cycle). Sits between the TX async FIFO read side and the TX pin.

Parameters:
DATA_WIDTH, 8, width of the parallel data word and number of data bits per frame.

Ports:
CLK  input  1  bit-rate clock.
RST  input  1  asynchronous active-low reset.
P_DATA  input  DATA_WIDTH  parallel word to send; sampled only when accepted.
Data_Valid  input  1  one-cycle strobe: P_DATA, PAR_EN and PAR_TYP are valid.
PAR_EN  input  1  1 = insert parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
TX_OUT  output  1  serial line; idles high.
Busy  output  1  high while a frame is on the line.

Behaviour:
- Reset: RST is asynchronous, active-low; clock is CLK. While reset is asserted: state = IDLE, TX_OUT = 1, Busy = 0, data/parity latches = 0, bit counter = 0.
- States: IDLE, START, DATA, PARITY, STOP.
- TX_OUT and Busy are registered. Both reflect the state entered at the same edge.
- IDLE: TX_OUT = 1, Busy = 0. If Data_Valid = 1 at a rising edge, latch P_DATA, PAR_EN and PAR_TYP, then go to START.
- START: TX_OUT = 0 for 1 cycle, then go to DATA. Busy = 1 in all states except IDLE.
- DATA: TX_OUT = latched_data[bit_cnt] for DATA_WIDTH cycles, bit_cnt running 0 to DATA_WIDTH-1. When the last bit completes, go to PARITY if latched PAR_EN = 1, else go to STOP. bit_cnt width is clog2(DATA_WIDTH); it clears on leaving DATA.
- PARITY: TX_OUT = ^latched_data when PAR_TYP = 0, ~^latched_data when PAR_TYP = 1. Lasts 1 cycle, then go to STOP.
- STOP: TX_OUT = 1 for 1 cycle. If Data_Valid = 1 in this cycle, latch the new word and go directly to START (back-to-back, Busy stays 1). Otherwise go to IDLE.
- Latency: Data_Valid sampled at edge k gives the start bit on TX_OUT during cycle k+1. Frame length is DATA_WIDTH + 2 cycles, or DATA_WIDTH + 3 with parity.
- Data_Valid in START, DATA or PARITY: ignored; the word is dropped. The upstream producer must gate Data_Valid with !Busy. No error flag.
- P_DATA, PAR_EN and PAR_TYP changing mid-frame: no effect; only the latched copies are used.
- Reset asserted mid-frame: the frame is aborted immediately. TX_OUT = 1, Busy = 0. No resume after release.
- Data_Valid held high continuously: one frame per STOP/IDLE acceptance, i.e. continuous back-to-back frames.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants: IDLE = 3'b000, START = 3'b001, DATA = 3'b010, PARITY = 3'b011, STOP = 3'b100
  - PAR_EVEN = 1'b0, PAR_ODD = 1'b1
  - START_BIT = 1'b0, STOP_BIT = 1'b1
  These are shared with the RX side.
- Sub-module uart_tx_serializer:
  - holds the data latch and bit counter
  - inputs: load, ser_en
  - outputs: ser_data, ser_done, and a parity bit computed from the latched word
- Top-level uart_tx holds the FSM and the TX_OUT mux (start / serial data / parity / stop).

Test Plan:
- Reset idle: hold RST = 0, then release with no Data_Valid -> TX_OUT = 1 and Busy = 0 for 20 cycles.
- Even parity: P_DATA = 0xA5, PAR_EN = 1, PAR_TYP = 0, Data_Valid for 1 cycle -> TX_OUT sequence 0, 1,0,1,0,0,1,0,1, 0, 1. Busy = 1 for exactly 11 cycles, then 0.
- Odd parity and no parity:
  - P_DATA = 0x00, PAR_EN = 1, PAR_TYP = 1 -> parity bit 1.
  - P_DATA = 0xFF, PAR_EN = 0 -> 0, 1×8, 1, frame of 10 cycles with no parity slot.
- Back-to-back: Data_Valid for 0x3C in IDLE, then Data_Valid for 0xC3 in the STOP cycle (PAR_EN = 0) -> two contiguous 10-bit frames with no idle gap. Busy stays high for 20 cycles. The second frame's data bits are 1,1,0,0,0,0,1,1.
- Ignore while busy: during DATA of 0x55, pulse Data_Valid with 0xAA and toggle P_DATA/PAR_EN -> the frame carries 0x55 unchanged. 0xAA is never transmitted. Return to IDLE after the stop bit.
- Reset mid-frame: assert RST during the 4th data bit -> TX_OUT = 1 and Busy = 0 with no clock edge needed. After release, a new Data_Valid with 0x81 produces a clean, complete frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors and line
// levels. The RX side uses the same constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b010,
    PARITY = 3'b011,
    STOP   = 3'b100
  } uart_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Parity bit for a word whose XOR-reduction is red_xor.
  function automatic logic parity_of(input logic red_xor, input logic typ);
    return (typ == PAR_ODD) ? ~red_xor : red_xor;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Producer-side handshake of the UART transmitter: word, parity setup,
// one-cycle valid strobe and the Busy back-pressure flag.
interface uart_tx_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  Busy;

  modport master (output P_DATA, Data_Valid, PAR_EN, PAR_TYP, input Busy);
  modport slave  (input P_DATA, Data_Valid, PAR_EN, PAR_TYP, output Busy);
endinterface

// File: rtl/uart_tx_serializer.sv
// Word latch and bit counter for the transmitter. ser_data is the bit the
// FSM registers onto the line at the coming edge: bit 0 when about to leave
// START, bit_cnt+1 while walking DATA.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  ser_en,
  output logic                  ser_data,
  output logic                  ser_done,
  output logic                  par_bit,
  output logic                  par_en_q
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_typ_q;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      nxt_idx;

  assign ser_done = ser_en && (bit_cnt == LAST);

  // Capture word and parity setup on acceptance; held for the whole frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else if (load) begin
      data_q    <= p_data;
      par_en_q  <= par_en;
      par_typ_q <= par_typ;
    end
  end

  // Index of the data bit currently on the line; clears when DATA ends.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                  bit_cnt <= '0;
    else if (load || ser_done) bit_cnt <= '0;
    else if (ser_en)           bit_cnt <= bit_cnt + 1'b1;
  end

  // Look-ahead index so the registered line output lands on the right bit.
  always_comb begin
    nxt_idx = '0;
    if (ser_en && !ser_done) nxt_idx = bit_cnt + 1'b1;
  end

  assign ser_data = data_q[nxt_idx];
  assign par_bit  = parity_of(^data_q, par_typ_q);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, one bit per CLK: start, DATA_WIDTH bits LSB first,
// optional parity, stop. A new word may be accepted in IDLE or in the STOP
// cycle, giving gap-free back-to-back frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic     CLK,
  input  logic     RST,
  uart_tx_if.slave bus,
  output logic     TX_OUT
);

  uart_state_e state;
  logic        busy_q;
  logic        load;
  logic        ser_en;
  logic        ser_data;
  logic        ser_done;
  logic        par_bit;
  logic        par_en_q;

  assign load     = bus.Data_Valid && ((state == IDLE) || (state == STOP));
  assign ser_en   = (state == DATA);
  assign bus.Busy = busy_q;

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .CLK      (CLK),
    .RST      (RST),
    .load     (load),
    .p_data   (bus.P_DATA),
    .par_en   (bus.PAR_EN),
    .par_typ  (bus.PAR_TYP),
    .ser_en   (ser_en),
    .ser_data (ser_data),
    .ser_done (ser_done),
    .par_bit  (par_bit),
    .par_en_q (par_en_q)
  );

  // Frame FSM; TX_OUT and Busy are registered alongside the state they belong to.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      TX_OUT <= STOP_BIT;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE, STOP: begin
          if (load) begin
            state  <= START;
            TX_OUT <= START_BIT;
            busy_q <= 1'b1;
          end else begin
            state  <= IDLE;
            TX_OUT <= STOP_BIT;
            busy_q <= 1'b0;
          end
        end
        START: begin
          state  <= DATA;
          TX_OUT <= ser_data;
        end
        DATA: begin
          if (!ser_done) begin
            TX_OUT <= ser_data;
          end else if (par_en_q) begin
            state  <= PARITY;
            TX_OUT <= par_bit;
          end else begin
            state  <= STOP;
            TX_OUT <= STOP_BIT;
          end
        end
        PARITY: begin
          state  <= STOP;
          TX_OUT <= STOP_BIT;
        end
        default: begin
          state  <= IDLE;
          TX_OUT <= STOP_BIT;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. Expected line bits come from a frame
// model built from the word, parity count and framing rules.
module tb_uart_tx;

  logic CLK;
  logic RST;
  logic tx;
  int   checks;
  int   failures;

  uart_tx_if #(.DATA_WIDTH(8)) bus ();

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .bus    (bus),
    .TX_OUT (tx)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Whole frame, LSB first: bit 0 is the start bit.
  function automatic logic [10:0] frame_bits(input logic [7:0] w, input logic pe, input logic pt);
    int   ones;
    logic par;
    ones = $countones(w);
    par  = pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
    if (pe) return {1'b1, par, w, 1'b0};
    return {1'b0, 1'b1, w, 1'b0};
  endfunction

  function automatic int frame_len(input logic pe);
    return pe ? 11 : 10;
  endfunction

  task automatic drive(input logic [7:0] w, input logic pe, input logic pt);
    bus.P_DATA     = w;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Data_Valid = 1'b1;
  endtask

  task automatic test_reset;
    RST = 1'b0;
    bus.Data_Valid = 1'b0;
    bus.P_DATA = '0;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (tx !== 1'b1 || bus.Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: tx=%b busy=%b, want tx=1 busy=0", tx, bus.Busy);
    end
    RST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      checks++;
      if (tx !== 1'b1 || bus.Busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle c%0d: tx=%b busy=%b, want tx=1 busy=0", i, tx, bus.Busy);
      end
    end
  endtask

  // Single frames: even parity 0xA5, odd parity 0x00, no parity 0xFF.
  task automatic test_single_frames;
    logic [7:0]  w  [3];
    logic        pe [3];
    logic        pt [3];
    logic [10:0] exp;
    int          n;
    w[0] = 8'hA5; pe[0] = 1'b1; pt[0] = 1'b0;
    w[1] = 8'h00; pe[1] = 1'b1; pt[1] = 1'b1;
    w[2] = 8'hFF; pe[2] = 1'b0; pt[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp = frame_bits(w[k], pe[k], pt[k]);
      n   = frame_len(pe[k]);
      drive(w[k], pe[k], pt[k]);
      @(negedge CLK);
      bus.Data_Valid = 1'b0;
      for (int i = 0; i < n; i++) begin
        checks++;
        if (tx !== exp[i] || bus.Busy !== 1'b1) begin
          failures++;
          $display("FAIL single w=%h bit%0d: tx=%b busy=%b, want tx=%b busy=1", w[k], i, tx, bus.Busy, exp[i]);
        end
        @(negedge CLK);
      end
      checks++;
      if (tx !== 1'b1 || bus.Busy !== 1'b0) begin
        failures++;
        $display("FAIL single_end w=%h: tx=%b busy=%b, want tx=1 busy=0", w[k], tx, bus.Busy);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_back_to_back;
    logic [19:0] exp;
    logic [10:0] f1;
    logic [10:0] f2;
    f1  = frame_bits(8'h3C, 1'b0, 1'b0);
    f2  = frame_bits(8'hC3, 1'b0, 1'b0);
    exp = {f2[9:0], f1[9:0]};
    drive(8'h3C, 1'b0, 1'b0);
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (tx !== exp[i] || bus.Busy !== 1'b1) begin
        failures++;
        $display("FAIL b2b bit%0d: tx=%b busy=%b, want tx=%b busy=1", i, tx, bus.Busy, exp[i]);
      end
      if (i == 9) drive(8'hC3, 1'b0, 1'b0);
      @(negedge CLK);
      bus.Data_Valid = 1'b0;
    end
    checks++;
    if (tx !== 1'b1 || bus.Busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end: tx=%b busy=%b, want tx=1 busy=0", tx, bus.Busy);
    end
  endtask

  task automatic test_ignore_busy;
    logic [10:0] exp;
    exp = frame_bits(8'h55, 1'b1, 1'b1);
    drive(8'h55, 1'b1, 1'b1);
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (tx !== exp[i] || bus.Busy !== 1'b1) begin
        failures++;
        $display("FAIL ignore bit%0d: tx=%b busy=%b, want tx=%b busy=1", i, tx, bus.Busy, exp[i]);
      end
      if (i == 3) drive(8'hAA, 1'b0, 1'b0);
      @(negedge CLK);
      bus.Data_Valid = 1'b0;
      bus.P_DATA = 8'($urandom);
      bus.PAR_EN = ~bus.PAR_EN;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx !== 1'b1 || bus.Busy !== 1'b0) begin
        failures++;
        $display("FAIL ignore_idle c%0d: tx=%b busy=%b, want tx=1 busy=0", i, tx, bus.Busy);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset_mid;
    logic [10:0] exp;
    exp = frame_bits(8'h00, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    // Walk start bit and data bits 0..3; reset lands during data bit 3.
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (tx !== exp[i] || bus.Busy !== 1'b1) begin
        failures++;
        $display("FAIL rstmid bit%0d: tx=%b busy=%b, want tx=%b busy=1", i, tx, bus.Busy, exp[i]);
      end
      if (i < 4) @(negedge CLK);
    end
    RST = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || bus.Busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async: tx=%b busy=%b, want tx=1 busy=0", tx, bus.Busy);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (tx !== 1'b1 || bus.Busy !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_noresume c%0d: tx=%b busy=%b, want tx=1 busy=0", i, tx, bus.Busy);
      end
    end
    exp = frame_bits(8'h81, 1'b1, 1'b0);
    drive(8'h81, 1'b1, 1'b0);
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (tx !== exp[i] || bus.Busy !== 1'b1) begin
        failures++;
        $display("FAIL rstmid_new bit%0d: tx=%b busy=%b, want tx=%b busy=1", i, tx, bus.Busy, exp[i]);
      end
      @(negedge CLK);
    end
    checks++;
    if (tx !== 1'b1 || bus.Busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_new_end: tx=%b busy=%b, want tx=1 busy=0", tx, bus.Busy);
    end
  endtask

  // Random words/parity with random idle gaps or chained frames.
  task automatic test_random;
    logic [7:0]  w;
    logic        pe;
    logic        pt;
    logic [7:0]  nw;
    logic        npe;
    logic        npt;
    logic [10:0] exp;
    int          n;
    int          gap;
    bit          chain;
    w = 8'($urandom); pe = 1'($urandom); pt = 1'($urandom);
    drive(w, pe, pt);
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    for (int f = 0; f < 30; f++) begin
      exp   = frame_bits(w, pe, pt);
      n     = frame_len(pe);
      nw    = 8'($urandom); npe = 1'($urandom); npt = 1'($urandom);
      chain = (f < 29) && ($urandom_range(0, 2) == 0);
      for (int i = 0; i < n; i++) begin
        checks++;
        if (tx !== exp[i] || bus.Busy !== 1'b1) begin
          failures++;
          $display("FAIL rand f%0d w=%h pe=%b pt=%b bit%0d: tx=%b busy=%b, want tx=%b busy=1",
                   f, w, pe, pt, i, tx, bus.Busy, exp[i]);
        end
        bus.P_DATA = 8'($urandom);
        bus.PAR_EN = 1'($urandom);
        bus.PAR_TYP = 1'($urandom);
        if (i == n - 1 && chain) drive(nw, npe, npt);
        @(negedge CLK);
        bus.Data_Valid = 1'b0;
      end
      if (!chain) begin
        gap = $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) begin
          checks++;
          if (tx !== 1'b1 || bus.Busy !== 1'b0) begin
            failures++;
            $display("FAIL rand_idle f%0d c%0d: tx=%b busy=%b, want tx=1 busy=0", f, g, tx, bus.Busy);
          end
          @(negedge CLK);
        end
        if (f < 29) begin
          drive(nw, npe, npt);
          @(negedge CLK);
          bus.Data_Valid = 1'b0;
        end
      end
      w = nw; pe = npe; pt = npt;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_frames();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
